// File: rtl/deserializer_unit_cell_1_if.sv
// Serial-in / parallel-out bundle for the 8-word deserializer cell.
// master drives the serial side; slave presents the reassembled frame.
interface deserializer_unit_cell_1_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  ENABLE;
  logic                  SERIAL_IN;
  logic                  SERIAL_VALID;
  logic [WORD_WIDTH-1:0] PAR_OUT1;
  logic [WORD_WIDTH-1:0] PAR_OUT2;
  logic [WORD_WIDTH-1:0] PAR_OUT3;
  logic [WORD_WIDTH-1:0] PAR_OUT4;
  logic [WORD_WIDTH-1:0] PAR_OUT5;
  logic [WORD_WIDTH-1:0] PAR_OUT6;
  logic [WORD_WIDTH-1:0] PAR_OUT7;
  logic [WORD_WIDTH-1:0] PAR_OUT8;
  logic                  WORD_DONE;
  logic                  FRAME_DONE;
  logic [5:0]            BIT_COUNT;
  logic [3:0]            WORD_COUNT;

  modport master (
    output ENABLE, SERIAL_IN, SERIAL_VALID,
    input  PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
    input  PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
    input  WORD_DONE, FRAME_DONE, BIT_COUNT, WORD_COUNT
  );

  modport slave (
    input  ENABLE, SERIAL_IN, SERIAL_VALID,
    output PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
    output PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
    output WORD_DONE, FRAME_DONE, BIT_COUNT, WORD_COUNT
  );
endinterface

// File: rtl/deserializer_unit_cell_1.sv
// LSB-first serial to 8-word parallel deserializer.
// Words 1..7 are staged so the output frame updates in one edge.
module deserializer_unit_cell_1 #(
  parameter int WORD_WIDTH = 32
) (
  input logic CLK,
  input logic RESET,
  deserializer_unit_cell_1_if.slave bus
);

  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] stage [7];
  logic [WORD_WIDTH-1:0] par [8];
  logic [WORD_WIDTH-1:0] nxt;
  logic [5:0]            bit_cnt;
  logic [3:0]            word_cnt;
  logic                  word_done;
  logic                  frame_done;
  logic                  last_bit;

  assign nxt      = {bus.SERIAL_IN, shreg[WORD_WIDTH-1:1]};
  assign last_bit = (bit_cnt == 6'(WORD_WIDTH - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 7; i++) stage[i] <= '0;
      for (int i = 0; i < 8; i++) par[i] <= '0;
    end else if (!bus.ENABLE) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
    end else if (bus.SERIAL_VALID) begin
      shreg <= nxt;
      if (!last_bit) begin
        bit_cnt    <= bit_cnt + 6'd1;
        word_done  <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        bit_cnt   <= '0;
        word_done <= 1'b1;
        if (word_cnt != 4'd7) begin
          for (int i = 0; i < 7; i++)
            if (word_cnt == 4'(i)) stage[i] <= nxt;
          word_cnt   <= word_cnt + 4'd1;
          frame_done <= 1'b0;
        end else begin
          // whole frame lands at once from staging plus the live word
          for (int i = 0; i < 7; i++) par[i] <= stage[i];
          par[7]     <= nxt;
          word_cnt   <= '0;
          frame_done <= 1'b1;
        end
      end
    end else begin
      word_done  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  assign bus.PAR_OUT1   = par[0];
  assign bus.PAR_OUT2   = par[1];
  assign bus.PAR_OUT3   = par[2];
  assign bus.PAR_OUT4   = par[3];
  assign bus.PAR_OUT5   = par[4];
  assign bus.PAR_OUT6   = par[5];
  assign bus.PAR_OUT7   = par[6];
  assign bus.PAR_OUT8   = par[7];
  assign bus.WORD_DONE  = word_done;
  assign bus.FRAME_DONE = frame_done;
  assign bus.BIT_COUNT  = bit_cnt;
  assign bus.WORD_COUNT = word_cnt;

endmodule

// File: tb/tb_deserializer_unit_cell_1.sv
// Scoreboard bench for the deserializer: 32-bit and 8-bit instances.
// Stimulus pushes expected frames; a negedge monitor pops on FRAME_DONE.
module tb_deserializer_unit_cell_1;

  typedef struct {
    logic [31:0] w [8];
  } frame_t;

  logic CLK;
  logic RESET;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  frame_t exp_q [$];
  frame_t fa, fb;
  int  exp_wd  = 0;
  int  exp_fd  = 0;
  int  wd_seen = 0;
  int  fd_seen = 0;
  bit  wd_gap_en = 0;
  bit  fd_gap_en = 0;
  bit  wd_pv = 0;
  bit  fd_pv = 0;
  int  wd_last = 0;
  int  fd_last = 0;

  deserializer_unit_cell_1_if #(.WORD_WIDTH(32)) b32 ();
  deserializer_unit_cell_1_if #(.WORD_WIDTH(8))  b8 ();

  deserializer_unit_cell_1 #(.WORD_WIDTH(32)) dut32 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b32.slave)
  );

  deserializer_unit_cell_1 #(.WORD_WIDTH(8)) dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b8.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] par32(int k);
    case (k)
      0: return b32.PAR_OUT1;
      1: return b32.PAR_OUT2;
      2: return b32.PAR_OUT3;
      3: return b32.PAR_OUT4;
      4: return b32.PAR_OUT5;
      5: return b32.PAR_OUT6;
      6: return b32.PAR_OUT7;
      default: return b32.PAR_OUT8;
    endcase
  endfunction

  function automatic logic [7:0] par8(int k);
    case (k)
      0: return b8.PAR_OUT1;
      1: return b8.PAR_OUT2;
      2: return b8.PAR_OUT3;
      3: return b8.PAR_OUT4;
      4: return b8.PAR_OUT5;
      5: return b8.PAR_OUT6;
      6: return b8.PAR_OUT7;
      default: return b8.PAR_OUT8;
    endcase
  endfunction

  // monitor: compares every presented frame against the scoreboard
  always @(negedge CLK) begin
    if (b32.WORD_DONE) begin
      wd_seen++;
      if (wd_gap_en && wd_pv) check("wd_gap", 64'(cyc - wd_last), 64'd32);
      wd_last = cyc;
      wd_pv   = 1;
    end
    if (!wd_gap_en) wd_pv = 0;
    if (b32.FRAME_DONE) begin
      frame_t f;
      fd_seen++;
      if (exp_q.size() == 0) begin
        check("fd_unexpected", 64'd1, 64'd0);
      end else begin
        f = exp_q.pop_front();
        for (int k = 0; k < 8; k++)
          check($sformatf("par_out%0d", k + 1), 64'(par32(k)), 64'(f.w[k]));
      end
      if (fd_gap_en && fd_pv) check("fd_gap", 64'(cyc - fd_last), 64'd256);
      fd_last = cyc;
      fd_pv   = 1;
    end
    if (!fd_gap_en) fd_pv = 0;
  end

  task automatic send_bit32(logic b, bit stall);
    logic [5:0] bc;
    if (stall && $urandom_range(0, 99) < 30) begin
      b32.SERIAL_VALID = 1'b0;
      bc = b32.BIT_COUNT;
      @(posedge CLK); #1;
      check("stall_hold", 64'(b32.BIT_COUNT), 64'(bc));
    end
    b32.SERIAL_IN    = b;
    b32.SERIAL_VALID = 1'b1;
    @(posedge CLK); #1;
    b32.SERIAL_VALID = 1'b0;
  endtask

  task automatic send_word32(logic [31:0] w, int nbits, bit stall);
    for (int i = 0; i < nbits; i++) send_bit32(w[i], stall);
    if (nbits == 32) exp_wd++;
  endtask

  task automatic send_frame32(frame_t f, bit stall);
    exp_q.push_back(f);
    exp_fd++;
    for (int k = 0; k < 8; k++) send_word32(f.w[k], 32, stall);
    check("fd_latency", 64'(b32.FRAME_DONE), 64'd1);
  endtask

  task automatic send_bit8(logic b);
    b8.SERIAL_IN    = b;
    b8.SERIAL_VALID = 1'b1;
    @(posedge CLK); #1;
    b8.SERIAL_VALID = 1'b0;
  endtask

  initial begin
    logic [7:0] w8;
    int n8;
    fa.w[0] = 32'h00000001; fa.w[1] = 32'h80000000;
    fa.w[2] = 32'hA5A5A5A5; fa.w[3] = 32'h5A5A5A5A;
    fa.w[4] = 32'hFFFFFFFF; fa.w[5] = 32'h00000000;
    fa.w[6] = 32'h12345678; fa.w[7] = 32'hDEADBEEF;
    for (int k = 0; k < 8; k++) fb.w[k] = ~fa.w[k];

    RESET = 1'b0;
    b32.ENABLE = 1'b0; b32.SERIAL_IN = 1'b0; b32.SERIAL_VALID = 1'b0;
    b8.ENABLE  = 1'b0; b8.SERIAL_IN  = 1'b0; b8.SERIAL_VALID  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_par1", 64'(b32.PAR_OUT1), 64'd0);
    check("rst_par8", 64'(b32.PAR_OUT8), 64'd0);
    check("rst_bitcnt", 64'(b32.BIT_COUNT), 64'd0);
    check("rst_wordcnt", 64'(b32.WORD_COUNT), 64'd0);
    check("rst_wd", 64'(b32.WORD_DONE), 64'd0);
    check("rst_fd", 64'(b32.FRAME_DONE), 64'd0);
    RESET = 1'b1;
    b32.ENABLE = 1'b1;
    @(posedge CLK); #1;

    // single frame, no stalls
    wd_gap_en = 1;
    send_frame32(fa, 0);
    wd_gap_en = 0;
    repeat (3) @(posedge CLK);
    #1;

    // same frame with random stalls
    send_frame32(fa, 1);
    repeat (3) @(posedge CLK);
    #1;

    // ENABLE drop after 100 bits of frame B
    for (int k = 0; k < 3; k++) send_word32(fb.w[k], 32, 0);
    send_word32(fb.w[3], 4, 0);
    check("pre_drop_bitcnt", 64'(b32.BIT_COUNT), 64'd4);
    check("pre_drop_wordcnt", 64'(b32.WORD_COUNT), 64'd3);
    b32.ENABLE = 1'b0;
    @(posedge CLK); #1;
    b32.ENABLE = 1'b1;
    check("drop_bitcnt", 64'(b32.BIT_COUNT), 64'd0);
    check("drop_wordcnt", 64'(b32.WORD_COUNT), 64'd0);
    check("drop_par1", 64'(b32.PAR_OUT1), 64'(fa.w[0]));
    check("drop_par8", 64'(b32.PAR_OUT8), 64'(fa.w[7]));
    send_frame32(fb, 0);
    repeat (2) @(posedge CLK);
    #1;

    // back-to-back A then B
    fd_gap_en = 1;
    send_frame32(fa, 0);
    send_frame32(fb, 0);
    fd_gap_en = 0;
    repeat (2) @(posedge CLK);
    #1;

    // reset pulse during word 5
    for (int k = 0; k < 4; k++) send_word32(fa.w[k], 32, 0);
    send_word32(fa.w[4], 10, 0);
    RESET = 1'b0;
    #1;
    check("mid_rst_par1", 64'(b32.PAR_OUT1), 64'd0);
    check("mid_rst_par8", 64'(b32.PAR_OUT8), 64'd0);
    check("mid_rst_bitcnt", 64'(b32.BIT_COUNT), 64'd0);
    check("mid_rst_wordcnt", 64'(b32.WORD_COUNT), 64'd0);
    check("mid_rst_fd", 64'(b32.FRAME_DONE), 64'd0);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    send_frame32(fa, 0);
    repeat (4) @(posedge CLK);
    #1;

    check("wd_count", 64'(wd_seen), 64'(exp_wd));
    check("fd_count", 64'(fd_seen), 64'(exp_fd));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // WORD_WIDTH=8 instance, words 1..8
    b8.ENABLE = 1'b1;
    n8 = 0;
    for (int k = 1; k <= 8; k++) begin
      w8 = 8'(k);
      for (int i = 0; i < 8; i++) begin
        send_bit8(w8[i]);
        n8++;
        if (n8 == 63) check("w8_fd_early", 64'(b8.FRAME_DONE), 64'd0);
      end
    end
    check("w8_fd_at64", 64'(b8.FRAME_DONE), 64'd1);
    for (int k = 0; k < 8; k++)
      check($sformatf("w8_par%0d", k + 1), 64'(par8(k)), 64'(k + 1));
    @(posedge CLK); #1;
    check("w8_fd_pulse", 64'(b8.FRAME_DONE), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
